// File: rtl/ser_n_to_1.sv
// ser_n_to_1: parallel-to-serial serializer, LSB first, with a one-word
// holding buffer in front of the shift register for gapless streaming.
//
// Parameters:
//   Width   - word width in bits (2..64)
//   IdleBit - level driven on o_dat while no word is being shifted
//
// Ports:
//   i_clk  - serial bit clock, all state updates on posedge
//   i_rst  - asynchronous active-high reset
//   i_dat  - parallel word, bit 0 is transmitted first
//   i_vld  - i_dat valid; transfer on posedge with i_vld && o_rdy
//   o_rdy  - registered ready, high while the holding buffer is free
//   o_dat  - registered serial data
//   o_vld  - o_dat carries a word bit
//   o_frm  - o_dat carries bit 0 of a word
//   o_udf  - one-cycle pulse when the stream breaks after a finished word
//
// Optional feature macro: SER_PRBS_IDLE_EN
//   When defined, idle cycles carry a PRBS7 (x^7+x^6+1, seed 7'h7F)
//   instead of IdleBit. The LFSR only advances on idle cycles.

module ser_n_to_1 #(
    parameter int unsigned Width   = 8,
    parameter logic        IdleBit = 1'b0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [Width-1:0] i_dat,
    input  logic             i_vld,
    output logic             o_rdy,
    output logic             o_dat,
    output logic             o_vld,
    output logic             o_frm,
    output logic             o_udf
);

    localparam int unsigned CW = (Width > 1) ? $clog2(Width) : 1;
    localparam logic [CW-1:0] LAST = CW'(Width - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state;
    logic [Width-1:0] hold;
    logic             hvld;
    logic [Width-1:0] shr;
    logic [CW-1:0]    cnt;

    logic at_last;
    logic load;
    logic acc;
    logic hvld_nx;
    logic emit_idle;
    logic idle_bit;

    assign at_last = (state == SHIFT) && (cnt == LAST);
    assign load    = hvld && ((state == IDLE) || at_last);
    assign acc     = i_vld && o_rdy;

    // An idle bit goes out whenever nothing is loaded and no word is
    // mid-flight, including the cycle that ends a word without successor.
    assign emit_idle = !load && ((state == IDLE) || at_last);

    // Accept and load never coincide: o_rdy=1 implies the buffer is empty.
    always_comb begin
        hvld_nx = hvld;
        if (load) hvld_nx = 1'b0;
        if (acc) hvld_nx = 1'b1;
    end

`ifdef SER_PRBS_IDLE_EN
    logic [6:0] lfsr;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            lfsr <= 7'h7F;
        end else if (emit_idle) begin
            lfsr <= {lfsr[5:0], lfsr[6] ^ lfsr[5]};
        end
    end

    assign idle_bit = lfsr[6];
`else
    assign idle_bit = IdleBit;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= IDLE;
            hold  <= '0;
            hvld  <= 1'b0;
            shr   <= '0;
            cnt   <= '0;
            o_rdy <= 1'b0;
            o_dat <= IdleBit;
            o_vld <= 1'b0;
            o_frm <= 1'b0;
            o_udf <= 1'b0;
        end else begin
            hvld  <= hvld_nx;
            o_rdy <= !hvld_nx;
            o_frm <= 1'b0;
            o_udf <= 1'b0;
            if (acc) begin
                hold <= i_dat;
            end
            if (load) begin
                // Bit 0 leaves now; the rest waits in shr, LSB aligned.
                state <= SHIFT;
                cnt   <= '0;
                shr   <= hold >> 1;
                o_dat <= hold[0];
                o_vld <= 1'b1;
                o_frm <= 1'b1;
            end else if ((state == SHIFT) && !at_last) begin
                cnt   <= cnt + 1'b1;
                shr   <= shr >> 1;
                o_dat <= shr[0];
                o_vld <= 1'b1;
            end else begin
                if (at_last) begin
                    o_udf <= 1'b1;
                end
                state <= IDLE;
                cnt   <= '0;
                o_dat <= idle_bit;
                o_vld <= 1'b0;
            end
        end
    end

    // Only reachable when emit_idle is otherwise unused.
    logic unused_ok;
    assign unused_ok = emit_idle;

endmodule

// File: tb/tb_ser_n_to_1.sv
// tb_ser_n_to_1: randomized and directed bench for ser_n_to_1 at
// Width 4, 2 and 8 against a bit-stream reference model.

module tb_ser_n_to_1;

    localparam logic IB = 1'b0;

    typedef struct packed {
        logic vld;
        logic dat;
        logic frm;
        logic udf;
        logic rdy;
    } smp_t;

    logic       clk;
    logic       rst4, rst2, rst8;
    logic [3:0] d4;
    logic [1:0] d2;
    logic [7:0] d8;
    logic       v4, v2, v8;
    logic       r4, o4, vl4, f4, uf4;
    logic       r2, o2, vl2, f2, uf2;
    logic       r8, o8, vl8, f8, uf8;

    int total = 0;
    int bad   = 0;

    smp_t lg4[$];
    smp_t lg2[$];
    smp_t lg8[$];
    bit   on4 = 0;
    bit   on2 = 0;
    bit   on8 = 0;

    logic [63:0] wq[$];

    ser_n_to_1 #(.Width(4), .IdleBit(IB)) dut4 (
        .i_clk(clk), .i_rst(rst4), .i_dat(d4), .i_vld(v4),
        .o_rdy(r4), .o_dat(o4), .o_vld(vl4), .o_frm(f4), .o_udf(uf4)
    );

    ser_n_to_1 #(.Width(2), .IdleBit(IB)) dut2 (
        .i_clk(clk), .i_rst(rst2), .i_dat(d2), .i_vld(v2),
        .o_rdy(r2), .o_dat(o2), .o_vld(vl2), .o_frm(f2), .o_udf(uf2)
    );

    ser_n_to_1 #(.Width(8), .IdleBit(IB)) dut8 (
        .i_clk(clk), .i_rst(rst8), .i_dat(d8), .i_vld(v8),
        .o_rdy(r8), .o_dat(o8), .o_vld(vl8), .o_frm(f8), .o_udf(uf8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (on4) lg4.push_back({vl4, o4, f4, uf4, r4});
        if (on2) lg2.push_back({vl2, o2, f2, uf2, r2});
        if (on8) lg8.push_back({vl8, o8, f8, uf8, r8});
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic rdy_of(input int sel);
        logic r;
        case (sel)
            4:       r = r4;
            2:       r = r2;
            default: r = r8;
        endcase
        return r;
    endfunction

    // Present a word and wait (bounded) for the handshake edge.
    task automatic send(input int sel, input logic [63:0] w, input bit keep);
        bit acc;
        int n;
        case (sel)
            4:       begin d4 = w[3:0]; v4 = 1'b1; end
            2:       begin d2 = w[1:0]; v2 = 1'b1; end
            default: begin d8 = w[7:0]; v8 = 1'b1; end
        endcase
        acc = 0;
        n   = 0;
        while (!acc && n < 64) begin
            acc = (rdy_of(sel) == 1'b1);
            tick();
            n++;
        end
        chk("send_acc", 64'(acc), 64'(1));
        if (acc) chk("rdy_drop", 64'(rdy_of(sel)), 64'(0));
        if (!keep) begin
            case (sel)
                4:       v4 = 1'b0;
                2:       v2 = 1'b0;
                default: v8 = 1'b0;
            endcase
        end
    endtask

    // Reference: the valid bits must be exactly the accepted words,
    // LSB first, each word framed on its bit 0; an underrun pulse follows
    // a finished word that is not immediately followed by another bit.
    task automatic check_stream(input string tag, input smp_t lg[$],
                                input logic [63:0] ws[$], input int w,
                                input bit gapless);
        bit eb[$];
        int p;
        int first;
        int last;
        bit prev_end;
        foreach (ws[k]) begin
            for (int j = 0; j < w; j++) eb.push_back(ws[k][j]);
        end
        p        = 0;
        first    = -1;
        last     = -1;
        prev_end = 0;
        foreach (lg[i]) begin
            if (lg[i].vld) begin
                if (first < 0) first = i;
                last = i;
                if (p < eb.size()) begin
                    chk({tag, "_dat"}, 64'(lg[i].dat), 64'(eb[p]));
                    chk({tag, "_frm"}, 64'(lg[i].frm), 64'(p % w == 0));
                    if (p % w == 0) chk({tag, "_rdy_load"}, 64'(lg[i].rdy), 64'(1));
                end else begin
                    chk({tag, "_extra"}, 64'(p), 64'(eb.size()));
                end
                p++;
            end else begin
`ifndef SER_PRBS_IDLE_EN
                chk({tag, "_idle_dat"}, 64'(lg[i].dat), 64'(IB));
`endif
                chk({tag, "_idle_frm"}, 64'(lg[i].frm), 64'(0));
            end
            chk({tag, "_udf"}, 64'(lg[i].udf), 64'(prev_end && !lg[i].vld));
            prev_end = lg[i].vld && (p % w == 0);
        end
        chk({tag, "_count"}, 64'(p), 64'(eb.size()));
        if (gapless) chk({tag, "_span"}, 64'(last - first + 1), 64'(eb.size()));
    endtask

    initial begin
        logic [3:0]  tw;
        logic [7:0]  c3;
        logic [63:0] w;
        int          gap;
        int          nw;

        rst4 = 0; rst2 = 0; rst8 = 0;
        d4 = '0; d2 = '0; d8 = '0;
        v4 = 0; v2 = 0; v8 = 0;
        #1;
        rst4 = 1; rst2 = 1; rst8 = 1;
        #1;
        chk("rst_dat", 64'(o4), 64'(IB));
        chk("rst_vld", 64'(vl4), 64'(0));
        chk("rst_frm", 64'(f4), 64'(0));
        chk("rst_udf", 64'(uf4), 64'(0));
        chk("rst_rdy", 64'(r4), 64'(0));
        #5;
        rst4 = 0;
        rst2 = 0;

        // Single word 4'b1011 accepted at edge 2.
        tick();
        chk("rdy_edge1", 64'(r4), 64'(1));
        tw = 4'b1011;
        d4 = tw;
        v4 = 1;
        tick();
        chk("acc_rdy", 64'(r4), 64'(0));
        v4 = 0;
        for (int j = 0; j < 4; j++) begin
            tick();
            chk("one_dat", 64'(o4), 64'(tw[j]));
            chk("one_vld", 64'(vl4), 64'(1));
            chk("one_frm", 64'(f4), 64'(j == 0));
            chk("one_udf", 64'(uf4), 64'(0));
            if (j == 0) chk("one_rdy_load", 64'(r4), 64'(1));
        end
        tick();
        chk("one_end_vld", 64'(vl4), 64'(0));
        chk("one_end_udf", 64'(uf4), 64'(1));
`ifndef SER_PRBS_IDLE_EN
        chk("one_end_dat", 64'(o4), 64'(IB));
`endif
        tick();
        chk("one_udf_off", 64'(uf4), 64'(0));

        // Back-to-back A, 5, F with i_vld held high.
        lg4.delete();
        on4 = 1;
        send(4, 64'hA, 1);
        send(4, 64'h5, 1);
        send(4, 64'hF, 0);
        repeat (16) tick();
        on4 = 0;
        wq = '{64'hA, 64'h5, 64'hF};
        check_stream("b2b", lg4, wq, 4, 1);

        // Random words with random gaps, backpressure included.
        lg4.delete();
        wq.delete();
        on4 = 1;
        nw  = 24;
        for (int k = 0; k < nw; k++) begin
            w   = 64'($urandom_range(0, 15));
            gap = int'($urandom_range(0, 3));
            if (k == nw - 1) gap = 1;
            send(4, w, gap == 0);
            wq.push_back(w);
            repeat (gap) tick();
        end
        repeat (14) tick();
        on4 = 0;
        check_stream("rand", lg4, wq, 4, 0);

        // Width 2 continuous stream.
        lg2.delete();
        on2 = 1;
        send(2, 64'h1, 1);
        send(2, 64'h2, 1);
        send(2, 64'h3, 0);
        repeat (8) tick();
        on2 = 0;
        wq = '{64'h1, 64'h2, 64'h3};
        check_stream("w2", lg2, wq, 2, 1);

        // Width 8: idle after reset, then mid-word reset.
        rst8 = 0;
        for (int i = 1; i <= 8; i++) begin
            tick();
`ifdef SER_PRBS_IDLE_EN
            chk("prbs_dat", 64'(o8), 64'(i <= 7));
`else
            chk("idle_dat", 64'(o8), 64'(IB));
`endif
            chk("idle_vld", 64'(vl8), 64'(0));
        end
        c3 = 8'hC3;
        send(8, 64'(c3), 0);
        repeat (3) tick();
        chk("mid_vld", 64'(vl8), 64'(1));
        chk("mid_dat", 64'(o8), 64'(c3[2]));
        rst8 = 1;
        #1;
        chk("mrst_vld", 64'(vl8), 64'(0));
        chk("mrst_dat", 64'(o8), 64'(IB));
        chk("mrst_rdy", 64'(r8), 64'(0));
        chk("mrst_frm", 64'(f8), 64'(0));
        @(posedge clk);
        #1;
        rst8 = 0;
        lg8.delete();
        on8 = 1;
        tick();
        chk("mrst_rdy_up", 64'(r8), 64'(1));
        send(8, 64'h01, 0);
        repeat (12) tick();
        on8 = 0;
        wq = '{64'h01};
        check_stream("rst_rec", lg8, wq, 8, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
